// File: rtl/ccu_pkg.sv
// ccu_pkg: shared types and constants for the order sequencer.
// Provides the sequencer state encoding, default unit count/index width, and
// the index of each operation unit as seen on order_unit.
package ccu_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} state_t;

   localparam int N_UNITS_DEF = 12;
   localparam int UNIT_W_DEF  = 4;

   localparam logic [3:0] UNIT_ADD      = 4'd0;
   localparam logic [3:0] UNIT_SUB      = 4'd1;
   localparam logic [3:0] UNIT_MUL      = 4'd2;
   localparam logic [3:0] UNIT_DIV      = 4'd3;
   localparam logic [3:0] UNIT_SHL      = 4'd4;
   localparam logic [3:0] UNIT_SHR      = 4'd5;
   localparam logic [3:0] UNIT_AND      = 4'd6;
   localparam logic [3:0] UNIT_OR       = 4'd7;
   localparam logic [3:0] UNIT_XOR      = 4'd8;
   localparam logic [3:0] UNIT_CMP      = 4'd9;
   localparam logic [3:0] UNIT_LOAD     = 4'd10;
   localparam logic [3:0] UNIT_TRANSFER = 4'd11;

endpackage

// File: rtl/ccu_seq_watchdog.sv
// ccu_seq_watchdog: cycle counter that flags a unit which never answers.
// Ports: clk, rst_n (async active-low); clr restarts the count; en counts one
// cycle; expire is high while enabled on the last allowed cycle.
module ccu_seq_watchdog #(
   parameter int TIMEOUT_CYC = 1024,
   parameter int TO_W        = 11
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [TO_W-1:0] cnt;

   assign expire = en && cnt == TO_W'(TIMEOUT_CYC - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !expire) cnt <= cnt + TO_W'(1);

endmodule

// File: rtl/ccu_order_sequencer.sv
// ccu_order_sequencer: runs one MCU order at a time on one of the operation units.
// Ports: clk, rst_n (async active-low); order_valid/order_unit/order_ready take
// an order; unit_start/unit_ep are the per-unit start and end pulses; ep and
// busy report to the MCU; err_spurious/err_badunit/err_timeout are sticky,
// cleared by err_clr. Build option CCU_SEQ_TIMEOUT_EN adds the unit watchdog.
module ccu_order_sequencer
   import ccu_pkg::*;
#(
   parameter int N_UNITS     = N_UNITS_DEF,
   parameter int UNIT_W      = UNIT_W_DEF,
   parameter int TIMEOUT_CYC = 1024,
   parameter int TO_W        = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               order_valid,
   input  logic [UNIT_W-1:0]  order_unit,
   output logic               order_ready,
   output logic [N_UNITS-1:0] unit_start,
   input  logic [N_UNITS-1:0] unit_ep,
   output logic               ep,
   output logic               busy,
   output logic               err_spurious,
   output logic               err_badunit,
   output logic               err_timeout,
   input  logic               err_clr
);

   state_t             state, state_nx;
   logic [UNIT_W-1:0]  unit;
   logic [N_UNITS-1:0] sel;
   logic               accept, bad, own, expire, spur_set;

   assign sel         = {{(N_UNITS-1){1'b0}}, 1'b1} << unit;
   assign accept      = order_valid && state == ST_IDLE;
   assign bad         = int'(order_unit) >= N_UNITS;
   assign own         = state == ST_WAIT && |(unit_ep & sel);
   // The active unit may legally pulse during START/WAIT; any other pulse is stray.
   assign spur_set    = (state == ST_START || state == ST_WAIT) ? |(unit_ep & ~sel) : |unit_ep;
   assign order_ready = state == ST_IDLE;
   assign unit_start  = state == ST_START ? sel : '0;
   assign ep          = state == ST_DONE;
   assign busy        = state != ST_IDLE;

   always_comb
      state_nx = state == ST_IDLE  ? (accept ? (bad ? ST_DONE : ST_START) : ST_IDLE) :
                 state == ST_START ? ST_WAIT :
                 state == ST_WAIT  ? ((own || expire) ? ST_DONE : ST_WAIT) :
                                     ST_IDLE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= ST_IDLE;
         unit         <= '0;
         err_spurious <= 1'b0;
         err_badunit  <= 1'b0;
      end else begin
         state        <= state_nx;
         if (accept && !bad) unit <= order_unit;
         err_spurious <= spur_set || (err_spurious && !err_clr);
         err_badunit  <= (accept && bad) || (err_badunit && !err_clr);
      end

`ifdef CCU_SEQ_TIMEOUT_EN
   logic wd_expire;

   ccu_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_wd (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state == ST_START),
      .en     (state == ST_WAIT),
      .expire (wd_expire)
   );

   // A completion landing on the expiry cycle is a normal finish.
   assign expire = wd_expire && !own;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_timeout <= 1'b0;
      else err_timeout <= expire || (err_timeout && !err_clr);
`else
   logic unused_to;

   assign unused_to   = TIMEOUT_CYC > 0 && TO_W > 0;
   assign expire      = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ccu_order_sequencer.sv
// tb_ccu_order_sequencer: scoreboard bench for the order sequencer.
module tb_ccu_order_sequencer;

   logic        clk = 0, rst_n = 0, order_valid = 0, err_clr = 0;
   logic [3:0]  order_unit = 0;
   logic [11:0] unit_ep = 0;
   logic        order_ready, ep, busy, err_spurious, err_badunit, err_timeout;
   logic [11:0] unit_start;
   int          n_checks = 0, n_fail = 0;
   logic [2:0]  exp_q[$];

   always #5 clk = ~clk;

   ccu_order_sequencer #(.N_UNITS(12), .UNIT_W(4), .TIMEOUT_CYC(16), .TO_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .order_valid(order_valid), .order_unit(order_unit),
      .order_ready(order_ready), .unit_start(unit_start), .unit_ep(unit_ep), .ep(ep),
      .busy(busy), .err_spurious(err_spurious), .err_badunit(err_badunit),
      .err_timeout(err_timeout), .err_clr(err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Each ep must match a queued order; its flags {spurious,badunit,timeout} are checked then.
   always @(negedge clk)
      if (rst_n && ep) begin
         check("ep_pending", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            logic [2:0] f;
            f = exp_q.pop_front();
            check("ep_flags", {29'b0, err_spurious, err_badunit, err_timeout}, {29'b0, f});
         end
      end

   task automatic issue(input logic [3:0] u, input logic [2:0] flags);
      check("ready", order_ready, 1);
      order_valid = 1;
      order_unit  = u;
      exp_q.push_back(flags);
      tick;
      order_valid = 0;
      check("start", unit_start, u < 12 ? 12'b1 << u : 12'b0);
      check("ep_after_accept", ep, u >= 12);
   endtask

   task automatic finish_unit(input int u);
      unit_ep[u] = 1;
      tick;
      unit_ep = 0;
      check("ep_done", ep, 1);
   endtask

   task automatic clear_errs;
      err_clr = 1;
      tick;
      err_clr = 0;
   endtask

   initial begin
      #12 rst_n = 1;
      tick;
      check("rst_ready", order_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_start", unit_start, 0);
      check("rst_ep", ep, 0);
      check("rst_errs", {err_spurious, err_badunit, err_timeout}, 0);

      // unit 3, answering five cycles after start
      issue(3, 3'b000);
      tick;
      check("start_once", unit_start, 0);
      check("busy_wait", busy, 1);
      repeat (4) tick;
      check("no_early_ep", ep, 0);
      finish_unit(3);
      tick;
      check("ep_one_cycle", ep, 0);
      check("busy_after", busy, 0);
      check("ready_after", order_ready, 1);

      // stray pulse from another unit while waiting
      issue(7, 3'b100);
      tick;
      unit_ep[2] = 1;
      tick;
      unit_ep = 0;
      check("spur_set", err_spurious, 1);
      check("spur_no_ep", ep, 0);
      tick;
      finish_unit(7);
      tick;
      clear_errs;
      check("spur_clr", err_spurious, 0);

      // clear and a new error in the same cycle: error wins
      err_clr = 1;
      unit_ep[1] = 1;
      tick;
      err_clr = 0;
      unit_ep = 0;
      check("clr_vs_new", err_spurious, 1);
      clear_errs;
      check("clr_again", err_spurious, 0);

      // own and foreign pulse together: completion plus flag
      issue(5, 3'b100);
      tick;
      unit_ep[5] = 1;
      unit_ep[9] = 1;
      tick;
      unit_ep = 0;
      check("both_ep", ep, 1);
      check("both_spur", err_spurious, 1);
      tick;
      clear_errs;

      // own pulse in the START cycle does not complete the order
      issue(0, 3'b000);
      unit_ep[0] = 1;
      tick;
      unit_ep = 0;
      check("start_ep_ignored", ep, 0);
      check("start_ep_not_spur", err_spurious, 0);
      repeat (2) tick;
      check("still_busy", busy, 1);
      finish_unit(0);
      tick;

      // minimum latency, then back-to-back order right after ep
      issue(4, 3'b000);
      tick;
      finish_unit(4);
      tick;
      issue(11, 3'b000);
      tick;
      finish_unit(11);
      tick;

      // out-of-range unit
      issue(13, 3'b010);
      tick;
      check("bad_ep_gone", ep, 0);
      check("bad_ready", order_ready, 1);
      check("bad_flag", err_badunit, 1);
      clear_errs;
      check("bad_clr", err_badunit, 0);

`ifdef CCU_SEQ_TIMEOUT_EN
      issue(6, 3'b001);
      tick;
      repeat (16) begin
         check("wd_no_ep", ep, 0);
         tick;
      end
      check("wd_ep", ep, 1);
      check("wd_flag", err_timeout, 1);
      tick;
      clear_errs;
      issue(6, 3'b000);
      tick;
      repeat (15) tick;
      finish_unit(6);
      check("wd_coincide", err_timeout, 0);
      tick;
`else
      issue(6, 3'b000);
      repeat (40) tick;
      check("hang_busy", busy, 1);
      check("hang_no_to", err_timeout, 0);
      finish_unit(6);
      tick;
`endif

      // asynchronous reset in WAIT drops everything at once
      issue(2, 3'b000);
      tick;
      #2 rst_n = 0;
      void'(exp_q.pop_back());
      #1;
      check("arst_ready", order_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_start", unit_start, 0);
      check("arst_ep", ep, 0);
      #2 rst_n = 1;
      tick;
      unit_ep[2] = 1;
      tick;
      unit_ep = 0;
      check("post_rst_spur", err_spurious, 1);
      check("post_rst_no_ep", ep, 0);
      check("post_rst_idle", busy, 0);
      tick;
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ccu_order_sequencer.md
Name: ccu_order_sequencer

Overview:
Sequences execution of one decoded order at a time across the twelve arithmetic/transfer operation units of the control section. Accepts an order from the main control unit (MCU) via valid/ready and issues a one-cycle start pulse to the selected unit. Waits for that unit's end pulse, then returns a single combined end pulse and completion status to the MCU. Also polices spurious or duplicate end pulses and, optionally, hung units.

Parameters:
N_UNITS, 12, number of operation units (one start/end pair each)
UNIT_W, 4, width of unit index (ceil(log2(N_UNITS)))
TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only with CCU_SEQ_TIMEOUT_EN)
TO_W, 11, watchdog counter width (must hold TIMEOUT_CYC)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
order_valid  in  1  MCU presents an order
order_unit  in  UNIT_W  target unit index, 0..N_UNITS-1
order_ready  out  1  sequencer can accept an order (IDLE only)
unit_start  out  N_UNITS  one-hot, one-cycle start pulse to selected unit
unit_ep  in  N_UNITS  per-unit end pulses, one bit per unit
ep  out  1  one-cycle combined end pulse to MCU
busy  out  1  an order is in flight
err_spurious  out  1  sticky: end pulse from a non-active unit, or while idle
err_badunit  out  1  sticky: order_unit >= N_UNITS accepted
err_timeout  out  1  sticky: watchdog expiry (0 when feature compiled out)
err_clr  in  1  synchronous clear of all sticky error flags

Behaviour:
- Reset (async assert, sync release): state IDLE; order_ready=1; unit_start=0; ep=0; busy=0; all err_* = 0; latched unit index = 0.
- States: IDLE, START, WAIT, DONE.
- IDLE: order_ready=1. On order_valid & order_ready:
  - valid index: latch order_unit, go to START.
  - index >= N_UNITS: set err_badunit, go to DONE; no start pulse issued.
- START: unit_start[latched]=1 for exactly this cycle; busy=1; go to WAIT. Start is issued 1 cycle after acceptance.
- WAIT: busy=1.
  - unit_ep[latched]=1: go to DONE.
  - Any other unit_ep bit set: set err_spurious; remain waiting unless own bit is also set in the same cycle (completion wins).
- DONE: ep=1 for one cycle; busy=0 from the next cycle; return to IDLE.
- Minimum latency: acceptance to ep = 3 cycles when the unit answers in the cycle after start. A new order may be accepted the cycle after ep.
- End pulse in the START cycle is ignored for completion; it is flagged spurious only if from a different unit.
- Any unit_ep bit while IDLE or DONE: set err_spurious.
- err_clr and a simultaneous new error: the new error wins (flag stays 1).
- unit_ep is treated as already synchronous; no edge detection. A held-high ep causes a spurious flag after DONE.

Optional Feature:
- Macro: CCU_SEQ_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYC-1 without the own end pulse: set err_timeout and go to DONE, so ep still pulses and the MCU is not hung.
  - If the own end pulse and expiry coincide: normal completion, no error.
- Not defined: no counter; WAIT persists indefinitely; err_timeout tied 0.

Decomposition:
- Package ccu_pkg:
  - state enum (IDLE, START, WAIT, DONE)
  - N_UNITS / UNIT_W defaults
  - unit index constants (e.g. UNIT_ADD, UNIT_SUB, UNIT_MUL, UNIT_SHL, UNIT_SHR, UNIT_TRANSFER ...)
- Sub-module: ccu_seq_watchdog (counter, clear, expire output), instantiated only under CCU_SEQ_TIMEOUT_EN.

Test Plan:
- Reset, then order_unit=3 valid for 1 cycle → unit_start=12'h008 exactly 1 cycle later; unit_ep[3] 5 cycles after start → ep single pulse next cycle; busy low afterwards; order_ready high again.
- Order unit 7 in WAIT; unit_ep[2] pulses → err_spurious=1, no ep; later unit_ep[7] → ep; err_clr → err_spurious=0.
- Order unit 5; unit_ep[5] and unit_ep[9] in the same WAIT cycle → ep next cycle and err_spurious=1.
- order_unit=13 → err_badunit=1, unit_start stays 0, ep pulses 1 cycle after acceptance.
- With CCU_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16: unit never answers → err_timeout=1, ep pulses after 16 WAIT cycles; repeat with unit_ep on the 16th WAIT cycle → no error.
- Deassert rst_n during WAIT → all outputs return to reset values immediately; after release, unit_ep[latched] produces err_spurious and no ep.
